// File: rtl/sec_ksa_masked_adder.sv
// Boolean-masked Kogge-Stone adder: N_SHARES-share operands in, N_SHARES-share sum out,
// L+1 register stages. All nonlinear steps use a registered SecAND gadget.

module sec_ksa_secand #(
  parameter int K = 32,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ena,
  input  logic [K*N-1:0]       i_a,
  input  logic [K*N-1:0]       i_b,
  input  logic [K*N*(N-1)-1:0] i_r,
  output logic [K*N-1:0]       o_c
);
  localparam int NW = N*(N-1);

  logic [K-1:0] r_diag  [N];
  logic [K-1:0] r_cross [NW];
  logic [K-1:0] r_rnd   [NW];

  // Word r_ij sits at i*(N-1) + (j<i ? j : j-1); the diagonal has no word.
  function automatic int rIdx(input int i, input int j);
    return i*(N-1) + ((j < i) ? j : j-1);
  endfunction

  // The mask words are registered with the cross products so that r_ij and r_ji
  // cancel on the output side within the same operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_diag[i] <= '0;
      for (int w = 0; w < NW; w++) begin
        r_cross[w] <= '0;
        r_rnd[w]   <= '0;
      end
    end else if (i_ena) begin
      for (int i = 0; i < N; i++) begin
        r_diag[i] <= i_a[i*K +: K] & i_b[i*K +: K];
        for (int j = 0; j < N; j++) begin
          if (j != i) begin
            r_cross[rIdx(i, j)] <= (i_a[i*K +: K] & i_b[j*K +: K]) ^ i_r[rIdx(i, j)*K +: K];
          end
        end
      end
      for (int w = 0; w < NW; w++) r_rnd[w] <= i_r[w*K +: K];
    end
  end

  always_comb begin
    o_c = '0;
    for (int i = 0; i < N; i++) begin
      o_c[i*K +: K] = r_diag[i];
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          o_c[i*K +: K] = o_c[i*K +: K] ^ r_cross[rIdx(i, j)] ^ r_rnd[rIdx(j, i)];
        end
      end
    end
  end

endmodule

module sec_ksa_masked_adder #(
  parameter  int K_WIDTH  = 32,
  parameter  int N_SHARES = 8,
  localparam int L        = $clog2(K_WIDTH-1),
  localparam int RANDNUM  = 2*L*N_SHARES*(N_SHARES-1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          dvld,
  input  logic [K_WIDTH*RANDNUM-1:0]    rnd,
  input  logic [K_WIDTH*N_SHARES-1:0]   x,
  input  logic [K_WIDTH*N_SHARES-1:0]   y,
  output logic [K_WIDTH*N_SHARES-1:0]   z,
  output logic                          ovld
);
  localparam int KN = K_WIDTH*N_SHARES;
  localparam int RW = K_WIDTH*N_SHARES*(N_SHARES-1);

  function automatic logic [KN-1:0] shlShares(input logic [KN-1:0] v, input int s);
    logic [KN-1:0] res;
    res = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      res[i*K_WIDTH +: K_WIDTH] = v[i*K_WIDTH +: K_WIDTH] << s;
    end
    return res;
  endfunction

  logic [KN-1:0] r_p0;
  logic [KN-1:0] r_a    [L+1];
  logic [KN-1:0] r_gLin [L];
  logic [L:0]    r_vld;
  logic [KN-1:0] w_p    [L];
  logic [KN-1:0] w_g    [L+1];
  logic [KN-1:0] w_gAnd [L];

  // Linear path: propagate/sum register, sum delay line, linear G terms and the valid tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0  <= '0;
      r_vld <= '0;
      for (int k = 0; k <= L; k++) r_a[k] <= '0;
      for (int k = 0; k < L; k++) r_gLin[k] <= '0;
    end else if (ena) begin
      r_p0   <= x ^ y;
      r_a[0] <= x ^ y;
      r_vld  <= {r_vld[L-1:0], dvld};
      for (int k = 0; k < L; k++) begin
        r_a[k+1]  <= r_a[k];
        r_gLin[k] <= w_g[k];
      end
    end
  end

  assign w_p[0] = r_p0;

  sec_ksa_secand #(.K(K_WIDTH), .N(N_SHARES)) u_and0 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ena (ena),
    .i_a   (x),
    .i_b   (y),
    .i_r   (rnd[0 +: RW]),
    .o_c   (w_g[0])
  );

  for (genvar k = 0; k < L; k++) begin : g_level
    localparam int S = 1 << k;
    logic [KN-1:0] w_gSh;

    assign w_gSh = shlShares(w_g[k], S);

    sec_ksa_secand #(.K(K_WIDTH), .N(N_SHARES)) u_andG (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ena (ena),
      .i_a   (w_p[k]),
      .i_b   (w_gSh),
      .i_r   (rnd[(2*k+1)*RW +: RW]),
      .o_c   (w_gAnd[k])
    );

    assign w_g[k+1] = r_gLin[k] ^ w_gAnd[k];

    // The last level only needs the generate term.
    if (k < L-1) begin : g_prop
      logic [KN-1:0] w_pSh;

      assign w_pSh = shlShares(w_p[k], S);

      sec_ksa_secand #(.K(K_WIDTH), .N(N_SHARES)) u_andP (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ena (ena),
        .i_a   (w_p[k]),
        .i_b   (w_pSh),
        .i_r   (rnd[(2*k+2)*RW +: RW]),
        .o_c   (w_p[k+1])
      );
    end
  end

  assign z    = r_a[L] ^ shlShares(w_g[L], 1);
  assign ovld = r_vld[L];

endmodule

// File: tb/tb_sec_ksa_masked_adder.sv
// Scoreboard bench for sec_ksa_masked_adder at K=32/N=8, K=8/N=2 and K=16/N=3,
// all driven in lockstep from the same clock, reset, ena and dvld.

module tb_sec_ksa_masked_adder;
  localparam int K0 = 32, N0 = 8, L0 = 5, R0 = 2*L0*N0*(N0-1);
  localparam int K1 = 8,  N1 = 2, L1 = 3, R1 = 2*L1*N1*(N1-1);
  localparam int K2 = 16, N2 = 3, L2 = 4, R2 = 2*L2*N2*(N2-1);

  logic clk;
  logic rst_n;
  logic ena;
  logic dvld;

  logic [K0*R0-1:0] rnd0;
  logic [K0*N0-1:0] x0, y0, z0;
  logic             ovld0;
  logic [K1*R1-1:0] rnd1;
  logic [K1*N1-1:0] x1, y1, z1;
  logic             ovld1;
  logic [K2*R2-1:0] rnd2;
  logic [K2*N2-1:0] x2, y2, z2;
  logic             ovld2;

  logic [K0*N0-1:0] z0Hold;
  logic [K1*N1-1:0] z1Hold;
  logic [K2*N2-1:0] z2Hold;
  logic             ovld0Hold, ovld1Hold, ovld2Hold;

  logic [K0-1:0] q0[$];
  logic [K1-1:0] q1[$];
  logic [K2-1:0] q2[$];

  int vecCount;
  int missCount;

  sec_ksa_masked_adder #(.K_WIDTH(K0), .N_SHARES(N0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld),
    .rnd(rnd0), .x(x0), .y(y0), .z(z0), .ovld(ovld0)
  );

  sec_ksa_masked_adder #(.K_WIDTH(K1), .N_SHARES(N1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld),
    .rnd(rnd1), .x(x1), .y(y1), .z(z1), .ovld(ovld1)
  );

  sec_ksa_masked_adder #(.K_WIDTH(K2), .N_SHARES(N2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld),
    .rnd(rnd2), .x(x2), .y(y2), .z(z2), .ovld(ovld2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [K0-1:0] fold0(input logic [K0*N0-1:0] v);
    logic [K0-1:0] acc;
    acc = '0;
    for (int i = 0; i < N0; i++) acc = acc ^ v[i*K0 +: K0];
    return acc;
  endfunction

  function automatic logic [K1-1:0] fold1(input logic [K1*N1-1:0] v);
    return v[0 +: K1] ^ v[K1 +: K1];
  endfunction

  function automatic logic [K2-1:0] fold2(input logic [K2*N2-1:0] v);
    return v[0 +: K2] ^ v[K2 +: K2] ^ v[2*K2 +: K2];
  endfunction

  function automatic logic [K0*N0-1:0] mkShares0(input logic [K0-1:0] s);
    logic [K0*N0-1:0] r;
    logic [K0-1:0]    acc;
    acc = '0;
    r   = '0;
    for (int i = 0; i < N0-1; i++) begin
      r[i*K0 +: K0] = $urandom();
      acc = acc ^ r[i*K0 +: K0];
    end
    r[(N0-1)*K0 +: K0] = s ^ acc;
    return r;
  endfunction

  function automatic logic [K1*N1-1:0] mkShares1(input logic [K1-1:0] s);
    logic [K1-1:0] a;
    a = 8'($urandom());
    return {s ^ a, a};
  endfunction

  function automatic logic [K2*N2-1:0] mkShares2(input logic [K2-1:0] s);
    logic [K2-1:0] a, b;
    a = 16'($urandom());
    b = 16'($urandom());
    return {s ^ a ^ b, b, a};
  endfunction

  // Fresh masks for all three designs; zero clears every mask word.
  task automatic randRnd(input bit zero);
    for (int w = 0; w < K0*R0/32; w++) rnd0[w*32 +: 32] = zero ? 32'd0 : $urandom();
    for (int w = 0; w < K1*R1/32; w++) rnd1[w*32 +: 32] = zero ? 32'd0 : $urandom();
    for (int w = 0; w < K2*R2/32; w++) rnd2[w*32 +: 32] = zero ? 32'd0 : $urandom();
  endtask

  // New random operand pairs for all designs; optionally record the expected sums.
  task automatic driveRandom(input bit zeroRnd, input bit push);
    logic [K0-1:0] a0, b0;
    logic [K1-1:0] a1, b1;
    logic [K2-1:0] a2, b2;
    a0 = $urandom();        b0 = $urandom();
    a1 = 8'($urandom());    b1 = 8'($urandom());
    a2 = 16'($urandom());   b2 = 16'($urandom());
    x0 = mkShares0(a0); y0 = mkShares0(b0);
    x1 = mkShares1(a1); y1 = mkShares1(b1);
    x2 = mkShares2(a2); y2 = mkShares2(b2);
    randRnd(zeroRnd);
    if (push) begin
      q0.push_back(a0 + b0);
      q1.push_back(a1 + b1);
      q2.push_back(a2 + b2);
    end
  endtask

  task automatic flushPipe();
    ena  = 1'b1;
    dvld = 1'b0;
    repeat (8) begin
      @(negedge clk);
      driveRandom(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    dvld  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      driveRandom(1'b0, 1'b0);
    end
    @(negedge clk);
    vecCount++; if (z0 !== '0)    begin missCount++; $display("[TB] FAIL reset_z0 got %h want 0", z0); end
    vecCount++; if (ovld0 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ovld0 got %b want 0", ovld0); end
    vecCount++; if (z1 !== '0)    begin missCount++; $display("[TB] FAIL reset_z1 got %h want 0", z1); end
    vecCount++; if (ovld1 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ovld1 got %b want 0", ovld1); end
    vecCount++; if (z2 !== '0)    begin missCount++; $display("[TB] FAIL reset_z2 got %h want 0", z2); end
    vecCount++; if (ovld2 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ovld2 got %b want 0", ovld2); end
    dvld  = 1'b0;
    rst_n = 1'b1;
  endtask

  // One tagged operand pair on the K=32 design; the sum must appear after exactly 6 edges.
  task automatic test_vector(input logic [K0-1:0] a, input logic [K0-1:0] b,
                             input logic [K0-1:0] expSum, input bit zeroRnd, input string name);
    flushPipe();
    @(negedge clk);
    x0 = mkShares0(a);
    y0 = mkShares0(b);
    randRnd(zeroRnd);
    dvld = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        vecCount++;
        if (ovld0 !== 1'b0) begin missCount++; $display("[TB] FAIL %s_early got ovld=%b want 0", name, ovld0); end
      end
      if (c == 6) begin
        vecCount++;
        if (ovld0 !== 1'b1) begin missCount++; $display("[TB] FAIL %s_ovld got %b want 1", name, ovld0); end
        vecCount++;
        if (fold0(z0) !== expSum) begin missCount++; $display("[TB] FAIL %s got %h want %h", name, fold0(z0), expSum); end
      end
      dvld = 1'b0;
      driveRandom(zeroRnd, 1'b0);
    end
  endtask

  task automatic test_dvld_pulse();
    flushPipe();
    @(negedge clk);
    dvld = 1'b1;
    driveRandom(1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vecCount++;
      if (ovld0 !== (c == 6)) begin missCount++; $display("[TB] FAIL pulse0_c%0d got %b want %b", c, ovld0, (c == 6)); end
      vecCount++;
      if (ovld1 !== (c == 4)) begin missCount++; $display("[TB] FAIL pulse1_c%0d got %b want %b", c, ovld1, (c == 4)); end
      vecCount++;
      if (ovld2 !== (c == 5)) begin missCount++; $display("[TB] FAIL pulse2_c%0d got %b want %b", c, ovld2, (c == 5)); end
      dvld = 1'b0;
      driveRandom(1'b0, 1'b0);
    end
  endtask

  // One streaming cycle: score what the last edge produced, then drive the next operands.
  task automatic streamCycle(input bit en, input bit valid, input bit zeroRnd);
    logic [K0-1:0] e0;
    logic [K1-1:0] e1;
    logic [K2-1:0] e2;
    @(negedge clk);
    if (ena) begin
      if (ovld0) begin
        vecCount++;
        if (q0.size() == 0) begin missCount++; $display("[TB] FAIL stream0_extra got ovld=1 want no result"); end
        else begin
          e0 = q0.pop_front();
          if (fold0(z0) !== e0) begin missCount++; $display("[TB] FAIL stream0 got %h want %h", fold0(z0), e0); end
        end
      end
      if (ovld1) begin
        vecCount++;
        if (q1.size() == 0) begin missCount++; $display("[TB] FAIL stream1_extra got ovld=1 want no result"); end
        else begin
          e1 = q1.pop_front();
          if (fold1(z1) !== e1) begin missCount++; $display("[TB] FAIL stream1 got %h want %h", fold1(z1), e1); end
        end
      end
      if (ovld2) begin
        vecCount++;
        if (q2.size() == 0) begin missCount++; $display("[TB] FAIL stream2_extra got ovld=1 want no result"); end
        else begin
          e2 = q2.pop_front();
          if (fold2(z2) !== e2) begin missCount++; $display("[TB] FAIL stream2 got %h want %h", fold2(z2), e2); end
        end
      end
    end else begin
      vecCount++;
      if (z0 !== z0Hold || ovld0 !== ovld0Hold) begin missCount++; $display("[TB] FAIL stall0 got %h/%b want %h/%b", z0, ovld0, z0Hold, ovld0Hold); end
      vecCount++;
      if (z1 !== z1Hold || ovld1 !== ovld1Hold) begin missCount++; $display("[TB] FAIL stall1 got %h/%b want %h/%b", z1, ovld1, z1Hold, ovld1Hold); end
      vecCount++;
      if (z2 !== z2Hold || ovld2 !== ovld2Hold) begin missCount++; $display("[TB] FAIL stall2 got %h/%b want %h/%b", z2, ovld2, z2Hold, ovld2Hold); end
    end
    z0Hold = z0; ovld0Hold = ovld0;
    z1Hold = z1; ovld1Hold = ovld1;
    z2Hold = z2; ovld2Hold = ovld2;
    ena  = en;
    dvld = valid;
    driveRandom(zeroRnd, en && valid);
  endtask

  task automatic test_stream(input int cycles, input int stallAt, input bit zeroRnd, input string name);
    flushPipe();
    q0.delete(); q1.delete(); q2.delete();
    for (int n = 0; n < cycles; n++) begin
      streamCycle(!(n >= stallAt && n < stallAt + 3), 1'b1, zeroRnd);
    end
    for (int n = 0; n < 8; n++) streamCycle(1'b1, 1'b0, zeroRnd);
    vecCount++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      missCount++;
      $display("[TB] FAIL %s_drain got %0d/%0d/%0d pending want 0/0/0", name, q0.size(), q1.size(), q2.size());
    end
  endtask

  task automatic test_reset_mid();
    flushPipe();
    q0.delete(); q1.delete(); q2.delete();
    for (int n = 0; n < 10; n++) streamCycle(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecCount++; if (z0 !== '0 || ovld0 !== 1'b0) begin missCount++; $display("[TB] FAIL midreset0 got %h/%b want 0/0", z0, ovld0); end
    vecCount++; if (z1 !== '0 || ovld1 !== 1'b0) begin missCount++; $display("[TB] FAIL midreset1 got %h/%b want 0/0", z1, ovld1); end
    vecCount++; if (z2 !== '0 || ovld2 !== 1'b0) begin missCount++; $display("[TB] FAIL midreset2 got %h/%b want 0/0", z2, ovld2); end
    q0.delete(); q1.delete(); q2.delete();
    dvld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    dvld      = 1'b0;
    driveRandom(1'b0, 1'b0);
    z0Hold = '0; z1Hold = '0; z2Hold = '0;
    ovld0Hold = 1'b0; ovld1Hold = 1'b0; ovld2Hold = 1'b0;

    test_reset();
    test_vector(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, "wrap");
    test_vector(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, "carry31");
    test_vector(32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b0, "mixed");
    test_vector(32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b1, "zerornd");
    test_dvld_pulse();
    test_stream(1500, 700, 1'b0, "stream");
    test_stream(200, 1000, 1'b1, "stream_zerornd");
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
